// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and address-map constants for the APB master bridge
//
// Purpose : FSM state type, APB window base, per-slave span and data width.
// Contents: apb_state_e, APB_BASE_HI, APB_SLV_SPAN, APB_SLV_LSB, APB_DATA_W.

package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   // Upper half-word of every mapped peripheral address.
   localparam logic [15:0] APB_BASE_HI  = 16'h1000;
   // Address span owned by each slave; slave i starts at base + i*span.
   localparam logic [31:0] APB_SLV_SPAN = 32'h1000;
   // Bit position of the slave index inside the address.
   localparam int          APB_SLV_LSB  = $clog2(APB_SLV_SPAN);
   localparam int          APB_DATA_W   = 32;

endpackage

// File: rtl/apb_decoder.sv
// rtl/apb_decoder.sv - combinational CPU-address to one-hot APB slave select decoder
//
// Purpose : decide whether an address falls in an implemented slave window and
//           produce the matching one-hot select.
// Ports   : addr_i   [31:0]       CPU byte address
//           sel_o    [NUM_SLV-1:0] one-hot slave select (all zero when unmapped)
//           mapped_o               address hits an implemented slave

module apb_decoder
   import apb_pkg::*;
#(
   parameter int NUM_SLV = 4
) (
   input  logic [31:0]        addr_i,
   output logic [NUM_SLV-1:0] sel_o,
   output logic               mapped_o
);

   logic [3:0] slv_idx;
   logic       unused_addr_bits;

   assign slv_idx  = addr_i[APB_SLV_LSB +: 4];
   assign mapped_o = (addr_i[31:16] == APB_BASE_HI) && (int'(slv_idx) < NUM_SLV);

   // Offset within a slave window is the slave's own business.
   assign unused_addr_bits = ^addr_i[APB_SLV_LSB-1:0];

   always_comb begin
      sel_o = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         sel_o[i] = mapped_o && (int'(slv_idx) == i);
      end
   end

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB master bridge for the CPU data bus
//
// Purpose : accept one CPU request at a time, decode it to a slave, run the APB
//           SETUP/ACCESS handshake and return a registered one-cycle completion.
//           Unmapped addresses complete immediately with err=1.
// Option  : APB_TIMEOUT_EN - abort an ACCESS phase after TIMEOUT_CYC cycles
//           without PREADY and complete with err=1.
// Ports   : PCLK, PRESET (async, active high)
//           CPU side : transfer, write, addr, wdata -> rdata, ready, err
//           APB side : PADDR, PWRITE, PENABLE, PWDATA, PSEL <- PRDATA, PREADY

module apb_master
   import apb_pkg::*;
#(
   parameter int NUM_SLV     = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                          PCLK,
   input  logic                          PRESET,
   input  logic                          transfer,
   input  logic                          write,
   input  logic [APB_DATA_W-1:0]         addr,
   input  logic [APB_DATA_W-1:0]         wdata,
   output logic [APB_DATA_W-1:0]         rdata,
   output logic                          ready,
   output logic                          err,
   output logic [APB_DATA_W-1:0]         PADDR,
   output logic                          PWRITE,
   output logic                          PENABLE,
   output logic [APB_DATA_W-1:0]         PWDATA,
   output logic [NUM_SLV-1:0]            PSEL,
   input  logic [NUM_SLV*APB_DATA_W-1:0] PRDATA,
   input  logic [NUM_SLV-1:0]            PREADY
);

   apb_state_e              state_q;
   logic [APB_DATA_W-1:0]   rdata_q;
   logic                    ready_q;
   logic                    err_q;
   logic [APB_DATA_W-1:0]   paddr_q;
   logic                    pwrite_q;
   logic                    penable_q;
   logic [APB_DATA_W-1:0]   pwdata_q;
   logic [NUM_SLV-1:0]      psel_q;

   logic [NUM_SLV-1:0]      dec_sel;
   logic                    dec_mapped;
   logic [APB_DATA_W-1:0]   prdata_sel;
   logic                    pready_sel;

   apb_decoder #(
      .NUM_SLV (NUM_SLV)
   ) u_decoder (
      .addr_i   (addr),
      .sel_o    (dec_sel),
      .mapped_o (dec_mapped)
   );

   // psel_q is one-hot or zero, so an OR-mux picks out the selected slave's
   // response and every other slave's PRDATA/PREADY is masked off.
   always_comb begin
      prdata_sel = '0;
      pready_sel = 1'b0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (psel_q[i]) begin
            prdata_sel = prdata_sel | PRDATA[i*APB_DATA_W +: APB_DATA_W];
            pready_sel = pready_sel | PREADY[i];
         end
      end
   end

`ifdef APB_TIMEOUT_EN
   localparam int             CNT_W    = (TIMEOUT_CYC > 255) ? 16 : 8;
   // Abort on the TIMEOUT_CYC-th stalled ACCESS cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign cnt_d = cnt_q + 1'b1;
`else
   logic unused_timeout_cyc;
   assign unused_timeout_cyc = (TIMEOUT_CYC > 0);
`endif

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q   <= IDLE;
         rdata_q   <= '0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         paddr_q   <= '0;
         pwrite_q  <= 1'b0;
         penable_q <= 1'b0;
         pwdata_q  <= '0;
         psel_q    <= '0;
`ifdef APB_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (transfer) begin
                  paddr_q  <= addr;
                  pwrite_q <= write;
                  pwdata_q <= wdata;
                  if (dec_mapped) begin
                     psel_q  <= dec_sel;
                     state_q <= SETUP;
                  end else begin
                     // Unmapped: answer straight from IDLE, bus untouched.
                     rdata_q <= '0;
                     err_q   <= 1'b1;
                     ready_q <= 1'b1;
                  end
               end
            end

            SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ACCESS;
`ifdef APB_TIMEOUT_EN
               cnt_q     <= '0;
`endif
            end

            ACCESS: begin
               if (pready_sel) begin
                  rdata_q   <= pwrite_q ? '0 : prdata_sel;
                  err_q     <= 1'b0;
                  ready_q   <= 1'b1;
                  psel_q    <= '0;
                  penable_q <= 1'b0;
                  state_q   <= IDLE;
               end
`ifdef APB_TIMEOUT_EN
               // PREADY is tested first, so a late ready on the limit cycle wins.
               else if (cnt_q == CNT_LAST) begin
                  rdata_q   <= '0;
                  err_q     <= 1'b1;
                  ready_q   <= 1'b1;
                  psel_q    <= '0;
                  penable_q <= 1'b0;
                  state_q   <= IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
`endif
            end

            default: begin
               psel_q    <= '0;
               penable_q <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign rdata   = rdata_q;
   assign ready   = ready_q;
   assign err     = err_q;
   assign PADDR   = paddr_q;
   assign PWRITE  = pwrite_q;
   assign PENABLE = penable_q;
   assign PWDATA  = pwdata_q;
   assign PSEL    = psel_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - scoreboard testbench for apb_master

module tb_apb_master;

   localparam int NUM_SLV = 4;

   logic                    PCLK;
   logic                    PRESET;
   logic                    transfer;
   logic                    write;
   logic [31:0]             addr;
   logic [31:0]             wdata;
   logic [31:0]             rdata;
   logic                    ready;
   logic                    err;
   logic [31:0]             PADDR;
   logic                    PWRITE;
   logic                    PENABLE;
   logic [31:0]             PWDATA;
   logic [NUM_SLV-1:0]      PSEL;
   logic [NUM_SLV*32-1:0]   PRDATA;
   logic [NUM_SLV-1:0]      PREADY;

   apb_master #(
      .NUM_SLV     (NUM_SLV),
      .TIMEOUT_CYC (8)
   ) dut (
      .PCLK     (PCLK),
      .PRESET   (PRESET),
      .transfer (transfer),
      .write    (write),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .ready    (ready),
      .err      (err),
      .PADDR    (PADDR),
      .PWRITE   (PWRITE),
      .PENABLE  (PENABLE),
      .PWDATA   (PWDATA),
      .PSEL     (PSEL),
      .PRDATA   (PRDATA),
      .PREADY   (PREADY)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Slave model: the slave under test raises PREADY after wait_n ACCESS
   // cycles; every other slave shows others_ready, which the DUT must ignore.
   int   slv_idx      = 0;
   int   wait_n       = 0;
   logic others_ready = 1'b1;
   int   acc_cnt      = 0;

   always @(posedge PCLK) begin
      cyc     <= cyc + 1;
      acc_cnt <= PENABLE ? acc_cnt + 1 : 0;
   end

   always_comb begin
      PREADY = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         PREADY[i] = (i == slv_idx) ? (PSEL[i] && PENABLE && (acc_cnt >= wait_n))
                                    : others_ready;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every ready pulse must match the oldest expected response.
   always @(negedge PCLK) begin
      if (!PRESET && ready === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_ready", {31'd0, ready}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_rdata", rdata, e.rdata);
            chk("resp_err", {31'd0, err}, {31'd0, e.err});
            chk("resp_cycle", cyc, e.cyc);
         end
      end
   end

   // Call just after a posedge; drives the request for exactly one edge.
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit push, input logic [31:0] exp_rd, input logic exp_err,
                        input int lat);
      exp_t e;
      transfer = 1'b1;
      write    = w;
      addr     = a;
      wdata    = d;
      if (push) begin
         e.rdata = exp_rd;
         e.err   = exp_err;
         e.cyc   = cyc + lat;
         sb.push_back(e);
      end
      @(posedge PCLK); #1;
      transfer = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max_cyc);
      bit done = 0;
      for (int i = 0; i < max_cyc; i++) begin
         @(posedge PCLK);
         if (sb.size() == 0) begin
            done = 1;
            break;
         end
      end
      #1;
      if (!done) chk({name, "_timeout"}, sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      PRESET   = 1'b1;
      transfer = 1'b0;
      write    = 1'b0;
      addr     = '0;
      wdata    = '0;
      PRDATA   = {NUM_SLV{32'hFFFF_FFFF}};

      repeat (2) @(posedge PCLK);
      #1;
      chk("rst_rdata",   rdata, 0);
      chk("rst_ready",   {31'd0, ready}, 0);
      chk("rst_err",     {31'd0, err}, 0);
      chk("rst_paddr",   PADDR, 0);
      chk("rst_pwrite",  {31'd0, PWRITE}, 0);
      chk("rst_penable", {31'd0, PENABLE}, 0);
      chk("rst_pwdata",  PWDATA, 0);
      chk("rst_psel",    {28'd0, PSEL}, 0);
      PRESET = 1'b0;

      // Write slave 0, zero wait states.
      slv_idx = 0; wait_n = 0;
      @(posedge PCLK); #1;
      issue(1'b1, 32'h1000_0000, 32'h41, 1, 32'h0, 1'b0, 3);
      @(negedge PCLK);
      chk("w0_setup_psel",    {28'd0, PSEL}, 32'h1);
      chk("w0_setup_penable", {31'd0, PENABLE}, 0);
      chk("w0_pwrite",        {31'd0, PWRITE}, 1);
      chk("w0_pwdata",        PWDATA, 32'h41);
      chk("w0_paddr",         PADDR, 32'h1000_0000);
      @(negedge PCLK);
      chk("w0_access_psel",    {28'd0, PSEL}, 32'h1);
      chk("w0_access_penable", {31'd0, PENABLE}, 1);
      wait_done("w0", 10);
      chk("w0_idle_psel", {28'd0, PSEL}, 0);
      chk("w0_hold_paddr", PADDR, 32'h1000_0000);

      // Read slave 2 with 4 wait states; other slaves show all-ones / ready.
      slv_idx = 2; wait_n = 4;
      PRDATA[2*32 +: 32] = 32'hDEAD_BEEF;
      @(posedge PCLK); #1;
      issue(1'b0, 32'h1000_2004, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 7);
      @(negedge PCLK);
      chk("r2_setup_psel", {28'd0, PSEL}, 32'h4);
      for (int i = 0; i < 5; i++) begin
         @(negedge PCLK);
         chk("r2_access_penable", {31'd0, PENABLE}, 1);
         chk("r2_access_paddr", PADDR, 32'h1000_2004);
      end
      wait_done("r2", 10);

      // Unmapped: outside the window, then past the last implemented slave.
      @(posedge PCLK); #1;
      issue(1'b0, 32'h2000_0000, 32'h0, 1, 32'h0, 1'b1, 1);
      @(negedge PCLK);
      chk("unm_psel_a", {28'd0, PSEL}, 0);
      wait_done("unm", 5);
      chk("unm_psel_b", {28'd0, PSEL}, 0);

      slv_idx = 3; wait_n = 0;
      PRDATA[3*32 +: 32] = 32'h3333_3333;
      @(posedge PCLK); #1;
      issue(1'b0, 32'h1000_3FFC, 32'h0, 1, 32'h3333_3333, 1'b0, 3);
      wait_done("last_slv", 10);

      @(posedge PCLK); #1;
      issue(1'b0, 32'h1000_4000, 32'h0, 1, 32'h0, 1'b1, 1);
      @(negedge PCLK);
      chk("unm_hi_psel", {28'd0, PSEL}, 0);
      wait_done("unm_hi", 5);

      // Back-to-back, with a stray request during ACCESS.
      slv_idx = 1; wait_n = 2;
      @(posedge PCLK); #1;
      issue(1'b1, 32'h1000_1008, 32'h1234_5678, 1, 32'h0, 1'b0, 5);
      @(posedge PCLK); #1;
      transfer = 1'b1; write = 1'b1; addr = 32'h1000_0000; wdata = 32'hFFFF_0000;
      @(posedge PCLK); #1;
      transfer = 1'b0;
      chk("busy_psel",   {28'd0, PSEL}, 32'h2);
      chk("busy_paddr",  PADDR, 32'h1000_1008);
      chk("busy_pwdata", PWDATA, 32'h1234_5678);
      @(posedge PCLK); #1;
      @(posedge PCLK); #1;
      chk("b2b_ready_cycle", {31'd0, ready}, 1);
      slv_idx = 3; wait_n = 0;
      PRDATA[3*32 +: 32] = 32'h0BAD_F00D;
      issue(1'b0, 32'h1000_3000, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 3);
      chk("b2b_setup_psel", {28'd0, PSEL}, 32'h8);
      chk("b2b_setup_penable", {31'd0, PENABLE}, 0);
      wait_done("b2b", 10);

      // Reset during a stalled ACCESS.
      slv_idx = 1; wait_n = 1000000;
      @(posedge PCLK); #1;
      issue(1'b0, 32'h1000_1000, 32'h0, 0, 32'h0, 1'b0, 0);
      @(posedge PCLK); #1;
      chk("rst_mid_penable_before", {31'd0, PENABLE}, 1);
      #2 PRESET = 1'b1;
      #1;
      chk("rst_mid_psel", {28'd0, PSEL}, 0);
      chk("rst_mid_penable", {31'd0, PENABLE}, 0);
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      chk("rst_mid_rdata", rdata, 0);
      repeat (5) @(posedge PCLK);
      #1;
      slv_idx = 2; wait_n = 0;
      issue(1'b0, 32'h1000_2000, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 3);
      wait_done("post_rst", 10);

      // Slave that never answers.
      slv_idx = 0; wait_n = 1000000;
      @(posedge PCLK); #1;
`ifdef APB_TIMEOUT_EN
      issue(1'b0, 32'h1000_0010, 32'h0, 1, 32'h0, 1'b1, 10);
      repeat (8) @(posedge PCLK);
      #1;
      chk("to_last_access_psel", {28'd0, PSEL}, 32'h1);
      @(posedge PCLK); #1;
      chk("to_dropped_psel", {28'd0, PSEL}, 0);
      chk("to_dropped_penable", {31'd0, PENABLE}, 0);
      wait_done("to", 10);
`else
      issue(1'b0, 32'h1000_0010, 32'h0, 0, 32'h0, 1'b0, 0);
      repeat (1000) @(posedge PCLK);
      #1;
      chk("hang_psel", {28'd0, PSEL}, 32'h1);
      chk("hang_penable", {31'd0, PENABLE}, 1);
      PRESET = 1'b1;
      @(posedge PCLK); #1;
      PRESET = 1'b0;
`endif

      repeat (3) @(posedge PCLK);
      #1;
      chk("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB master bridge sitting between the multi-cycle RISC-V core's data bus and the APB peripherals (UART, GPIO, timers). It decodes the CPU address into a one-hot PSEL, runs the APB SETUP/ACCESS protocol, and waits on the selected slave's PREADY. It returns read data and completion to the CPU as a registered one-cycle pulse, and flags unmapped addresses as errors.

## Interface
- NUM_SLV, 4: number of APB slaves (1..16); slave i decodes at 0x1000_0000 + i*0x1000.
- TIMEOUT_CYC, 255: ACCESS-phase cycle limit; used only when APB_TIMEOUT_EN is defined.

- PCLK  in  1  system clock. One clock only.
- PRESET  in  1  asynchronous, active-high reset.
- transfer  in  1  CPU request strobe; sampled only in IDLE.
- write  in  1  1 = write, 0 = read; sampled with transfer.
- addr  in  32  CPU byte address; sampled with transfer.
- wdata  in  32  CPU write data; sampled with transfer.
- rdata  out  32  registered read data; valid while ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  error flag (unmapped or timeout); valid while ready=1.
- PADDR  out  32  APB address; this block drives the full address and each slave slices its own bits.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB enable.
- PWDATA  out  32  APB write data.
- PSEL  out  NUM_SLV  one-hot slave select.
- PRDATA  in  NUM_SLV*32  flattened slave read data; slave i occupies bits [32i+31:32i].
- PREADY  in  NUM_SLV  per-slave ready.

## Operation
- States: IDLE, SETUP, ACCESS.
- **IDLE**
  - On transfer=1, latch addr, write and wdata into PADDR, PWRITE and PWDATA.
  - Mapped address: the address is mapped when addr[31:16]==16'h1000 and addr[15:12]<NUM_SLV. Latch the one-hot select and go to SETUP.
  - Unmapped address: stay in IDLE. Next cycle assert ready=1 and err=1 with rdata=0. No PSEL is ever asserted.
- **SETUP**
  - PSEL[sel]=1, PENABLE=0.
  - Unconditionally go to ACCESS.
- **ACCESS**
  - PSEL[sel]=1, PENABLE=1.
  - When PREADY[sel]=1:
    - Capture rdata = PRDATA[sel] for a read, or 0 for a write.
    - Set ready=1 and err=0 on the next cycle.
    - Clear PSEL and PENABLE, and return to IDLE.
  - Only the selected slave's PREADY and PRDATA are observed; all other bits are ignored.
- **Requests while busy**
  - transfer in SETUP or ACCESS is ignored (not queued). The CPU issues the next request only after ready.
  - A transfer in the same cycle that ready=1 is accepted, because the FSM is already in IDLE.
- **Held values**
  - PADDR, PWRITE and PWDATA stay stable from SETUP through the end of ACCESS.
  - After completion they hold their last values until the next accepted transfer.
- **rdata and err** hold until the next completion. ready is high for exactly one cycle.

## Timing
- Reset values: rdata=0, ready=0, err=0, PADDR=0, PWRITE=0, PENABLE=0, PWDATA=0, PSEL=0, state=IDLE.
- Reset mid-transfer: PSEL and PENABLE drop asynchronously and no ready pulse is issued.
- Mapped access with zero wait states:
  - transfer sampled at edge 0.
  - SETUP in cycle 1.
  - ACCESS in cycle 2, with PREADY=1.
  - ready=1 in cycle 3.
  - Latency: 3 cycles.
- Each slave wait cycle adds 1 cycle of latency.
- Unmapped access: ready=1 and err=1 one cycle after transfer.
- Maximum throughput: one transfer per 3 cycles.

## Configuration
- Macro: APB_TIMEOUT_EN.
- **Defined:**
  - An 8..16-bit ACCESS cycle counter clears on entry to ACCESS and counts each ACCESS cycle without PREADY[sel].
  - When the count reaches TIMEOUT_CYC, drop PSEL and PENABLE, return to IDLE, and next cycle pulse ready=1 and err=1 with rdata=0.
  - If PREADY arrives in the same cycle the limit is hit, the transfer completes normally (PREADY wins).
- **Not defined:**
  - No counter is built.
  - ACCESS waits indefinitely, and err is raised only for unmapped addresses.

## Structure
- Package apb_pkg contains:
  - the state typedef apb_state_e (IDLE, SETUP, ACCESS);
  - APB_BASE_HI = 16'h1000;
  - APB_SLV_SPAN = 32'h1000;
  - APB_DATA_W = 32.
- Sub-module apb_decoder is purely combinational.
  - Input: addr. Outputs: the one-hot sel[NUM_SLV-1:0] and a mapped flag.
  - apb_master instantiates it once and registers its outputs.

## Test plan
- Write to slave 0 (UART DR) at 0x1000_0000, wdata=0x41, PREADY tied high.
  - Expect: PSEL=0001 with PENABLE=0 for 1 cycle, then PENABLE=1 for 1 cycle.
  - Expect: PWDATA=0x41, PWRITE=1, ready pulse at cycle 3, err=0, rdata=0.
- Read slave 2 at 0x1000_2004, PRDATA slice 2 = 0xDEAD_BEEF, PREADY[2] delayed 4 cycles.
  - Expect: ACCESS held for 5 cycles with PADDR stable.
  - Expect: rdata=0xDEAD_BEEF, ready at cycle 7.
  - Expect: other slaves' PRDATA/PREADY (set to 0xFFFF_FFFF/1) ignored.
- Read at unmapped 0x2000_0000.
  - Expect: PSEL stays 0, ready=1 and err=1 one cycle later, rdata=0.
- Back-to-back: second transfer asserted in the ready cycle of the first.
  - Expect: it is accepted, and its SETUP starts the next cycle.
  - A transfer pulsed during ACCESS is ignored (no extra PSEL).
- PRESET asserted in ACCESS with PREADY low.
  - Expect: PSEL and PENABLE go to 0 immediately.
  - Expect: no ready pulse after release.
  - Expect: the next transfer completes normally.
- With APB_TIMEOUT_EN and TIMEOUT_CYC=8, PREADY held low.
  - Expect: PSEL drops after 8 ACCESS cycles, then ready=1, err=1, rdata=0.
  - Without the macro: the bus remains in ACCESS after 1000 cycles with no ready.
